// File: rtl/ram_req_arbiter.sv
// Round-robin front-end sharing one NoC port to the RAM node among NREQ requesters,
// with credit-limited issue and tag-FIFO response routing. Define RAM_ARB_STATS_EN for issue/stall counters.
module ram_req_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int N          = 16,
  parameter int NODE       = 0,
  parameter int RAM_NODE   = 15,
  parameter int NREQ       = 4,
  parameter int CREDITS    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NREQ-1:0]                               req_valid,
  input  logic [NREQ-1:0]                               req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0]                    req_addr,
  input  logic [NREQ*WIDTH-1:0]                         req_data,
  output logic [NREQ-1:0]                               req_ready,
  output logic [NREQ-1:0]                               rsp_valid,
  output logic [WIDTH-1:0]                              rsp_data,
  output logic [WIDTH+ADDR_WIDTH+2+$clog2(N)-1:0]       o_packed_out,
  output logic [$clog2(N)-1:0]                          o_dest_out,
  output logic                                          o_valid_out,
  input  logic                                          o_ready_in,
  input  logic [WIDTH+$clog2(N)-1:0]                    i_packed_in,
  input  logic                                          i_valid_in,
  output logic                                          i_ready_out,
  output logic                                          err_out
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]                                   stat_issued,
  output logic [15:0]                                   stat_stall
`endif
);

  localparam int N_ADDR_WIDTH = $clog2(N);
  localparam int IDX_W        = $clog2(NREQ);
  localparam int PKT_W        = WIDTH + ADDR_WIDTH + 2 + N_ADDR_WIDTH;
  localparam int IN_W         = WIDTH + N_ADDR_WIDTH;
  localparam int CRD_W        = $clog2(CREDITS + 1);
  localparam int PTR_W        = (CREDITS > 1) ? $clog2(CREDITS) : 1;

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [WIDTH-1:0]      data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [CRD_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  tag_mem_q [CREDITS];
  logic              o_valid_q, o_valid_d;
  logic [PKT_W-1:0]  packed_q, packed_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  logic              slot_free, tag_full, tag_empty, issue, pop, cons_err;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx, cand;
  logic [NREQ-1:0]   grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CREDITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign slot_free = !o_valid_q || o_ready_in;
  assign tag_full  = (fifo_cnt_q == CRD_W'(CREDITS));
  assign tag_empty = (fifo_cnt_q == '0);
  // Gated by rst so nothing is offered to requesters while reset is held.
  assign issue     = rst && slot_free && (credits_q != '0) && (|req_valid) && !tag_full;
  assign pop       = i_valid_in && !tag_empty;
  assign cons_err  = rst && (|req_valid) && (credits_q != (CRD_W'(CREDITS) - fifo_cnt_q));
  assign grant     = issue ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    credits_d   = credits_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    o_valid_d   = o_valid_q;
    packed_d    = packed_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    if (issue) begin
      rr_ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      wr_ptr_d = ptr_inc(wr_ptr_q);
      packed_d = {req_write[grant_idx] ? data_arr[grant_idx] : {WIDTH{1'b0}},
                  addr_arr[grant_idx],
                  req_write[grant_idx],
                  ~req_write[grant_idx],
                  N_ADDR_WIDTH'(NODE)};
      o_valid_d = 1'b1;
    end else if (o_ready_in) begin
      o_valid_d = 1'b0;
    end

    case ({issue, pop})
      2'b10: begin
        credits_d  = credits_q - CRD_W'(1);
        fifo_cnt_d = fifo_cnt_q + CRD_W'(1);
      end
      2'b01: begin
        credits_d  = credits_q + CRD_W'(1);
        fifo_cnt_d = fifo_cnt_q - CRD_W'(1);
      end
      default: ;
    endcase

    if (pop) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      rsp_valid_d = NREQ'(1) << tag_mem_q[rd_ptr_q];
      rsp_data_d  = i_packed_in[IN_W-1 -: WIDTH];
    end

    // A response with nothing outstanding is dropped and flagged.
    if ((i_valid_in && tag_empty) || cons_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      credits_q   <= CRD_W'(CREDITS);
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      o_valid_q   <= 1'b0;
      packed_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      o_valid_q   <= o_valid_d;
      packed_q    <= packed_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (issue && stat_issued_q != 16'hFFFF) begin
      stat_issued_d = stat_issued_q + 16'd1;
    end
    if ((|req_valid) && !issue && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

  logic unused_src;
  assign unused_src = ^i_packed_in[N_ADDR_WIDTH-1:0];

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign o_packed_out = packed_q;
  assign o_valid_out  = o_valid_q;
  assign o_dest_out   = N_ADDR_WIDTH'(RAM_NODE);
  assign i_ready_out  = 1'b1;
  assign err_out      = err_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Directed self-checking bench for ram_req_arbiter (default parameters, stats disabled).
module tb_ram_req_arbiter;

  localparam int WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int NAW = 4;
  localparam int NREQ = 4;
  localparam int PKT_W = WIDTH + ADDR_WIDTH + 2 + NAW;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_write;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]      req_data;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]           rsp_data;
  logic [PKT_W-1:0]           o_packed_out;
  logic [NAW-1:0]             o_dest_out;
  logic                       o_valid_out;
  logic                       o_ready_in;
  logic [WIDTH+NAW-1:0]       i_packed_in;
  logic                       i_valid_in;
  logic                       i_ready_out;
  logic                       err_out;

  int total = 0;
  int bad = 0;

  ram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .o_packed_out(o_packed_out), .o_dest_out(o_dest_out), .o_valid_out(o_valid_out),
    .o_ready_in(o_ready_in), .i_packed_in(i_packed_in), .i_valid_in(i_valid_in),
    .i_ready_out(i_ready_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [7:0] d);
    req_write[i] = w;
    req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic idle();
    req_valid = '0;
    i_valid_in = 1'b0;
    i_packed_in = '0;
    o_ready_in = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    req_valid = 4'b1111;
    rst = 1'b0;
    step();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready1 got=%b exp=0000", req_ready); end
    step();
    @(negedge clk);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", o_valid_out); end
    total++; if (o_packed_out !== '0) begin bad++; $display("FAIL reset_packed got=%h exp=0", o_packed_out); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rspvalid got=%b exp=0000", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rspdata got=%h exp=00", rsp_data); end
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_out); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready2 got=%b exp=0000", req_ready); end
    total++; if (o_dest_out !== 4'd15) begin bad++; $display("FAIL reset_dest got=%0d exp=15", o_dest_out); end
    total++; if (i_ready_out !== 1'b1) begin bad++; $display("FAIL reset_iready got=%b exp=1", i_ready_out); end
    $display("reset checked");
    rst = 1'b1;
    req_valid = '0;
    step();
  endtask

  task automatic test_single_read();
    logic [PKT_W-1:0] exp_pkt;
    exp_pkt = {8'h00, 4'h5, 1'b0, 1'b1, 4'h0};
    set_req(2, 1'b0, 4'h5, 8'hEE);
    req_valid = 4'b0100;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL read_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
    total++; if (o_valid_out !== 1'b1) begin bad++; $display("FAIL read_ovalid got=%b exp=1", o_valid_out); end
    total++; if (o_packed_out !== exp_pkt) begin bad++; $display("FAIL read_packet got=%h exp=%h", o_packed_out, exp_pkt); end
    step();
    i_valid_in = 1'b1;
    i_packed_in = {8'h3C, 4'hF};
    @(negedge clk);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL read_ovalid_clear got=%b exp=0", o_valid_out); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL read_rsp_early got=%b exp=0000", rsp_valid); end
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL read_rspvalid got=%b exp=0100", rsp_valid); end
    total++; if (rsp_data !== 8'h3C) begin bad++; $display("FAIL read_rspdata got=%h exp=3c", rsp_data); end
    $display("read rsp valid=%b data=%h", rsp_valid, rsp_data);
    step();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL read_rsp_pulse got=%b exp=0000", rsp_valid); end
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", err_out); end
    step();
  endtask

  task automatic test_round_robin();
    logic [PKT_W-1:0] exp_pkt;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(i + 1), 8'h00);
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'(1 << k)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << k)); end
      if (k > 0) begin
        exp_pkt = {8'h00, 4'(k), 1'b0, 1'b1, 4'h0};
        total++; if (o_packed_out !== exp_pkt) begin bad++; $display("FAIL rr_packet%0d got=%h exp=%h", k, o_packed_out, exp_pkt); end
      end
      $display("rr cycle %0d grant=%b", k, req_ready);
      step();
    end
    @(negedge clk);
    exp_pkt = {8'h00, 4'd4, 1'b0, 1'b1, 4'h0};
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_nocredit got=%b exp=0000", req_ready); end
    total++; if (o_packed_out !== exp_pkt) begin bad++; $display("FAIL rr_packet3 got=%h exp=%h", o_packed_out, exp_pkt); end
    step();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_nocredit2 got=%b exp=0000", req_ready); end
    step();
  endtask

  task automatic test_credit_return();
    int tags [4];
    tags = '{2, 3, 0, 1};
    i_valid_in = 1'b1;
    i_packed_in = {8'h11, 4'hF};
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL cr_zero got=%b exp=0000", req_ready); end
    step();
    i_packed_in = {8'h22, 4'hF};
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL cr_wrap_grant got=%b exp=0001", req_ready); end
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL cr_rsp0 got=%b exp=0001", rsp_valid); end
    total++; if (rsp_data !== 8'h11) begin bad++; $display("FAIL cr_rsp0_data got=%h exp=11", rsp_data); end
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL cr_simul_grant got=%b exp=0010", req_ready); end
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL cr_rsp1 got=%b exp=0010", rsp_valid); end
    total++; if (rsp_data !== 8'h22) begin bad++; $display("FAIL cr_rsp1_data got=%h exp=22", rsp_data); end
    step();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL cr_empty_again got=%b exp=0000", req_ready); end
    req_valid = '0;
    step();
    for (int j = 0; j < 4; j++) begin
      i_valid_in = 1'b1;
      i_packed_in = {8'(8'h30 + j), 4'hF};
      step();
      i_valid_in = 1'b0;
      @(negedge clk);
      total++; if (rsp_valid !== 4'(1 << tags[j])) begin bad++; $display("FAIL cr_drain%0d got=%b exp=%b", j, rsp_valid, 4'(1 << tags[j])); end
      total++; if (rsp_data !== 8'(8'h30 + j)) begin bad++; $display("FAIL cr_drain%0d_data got=%h exp=%h", j, rsp_data, 8'(8'h30 + j)); end
      $display("drain rsp valid=%b data=%h", rsp_valid, rsp_data);
      step();
    end
    @(negedge clk);
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL cr_err got=%b exp=0", err_out); end
    step();
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] wr_pkt;
    logic [PKT_W-1:0] rd_pkt;
    wr_pkt = {8'hA5, 4'h9, 1'b1, 1'b0, 4'h0};
    rd_pkt = {8'h00, 4'h2, 1'b0, 1'b1, 4'h0};
    do_reset();
    o_ready_in = 1'b0;
    set_req(1, 1'b1, 4'h9, 8'hA5);
    set_req(3, 1'b0, 4'h2, 8'h5A);
    req_valid = 4'b0010;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant_wr got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (o_valid_out !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b exp=1", c, o_valid_out); end
      total++; if (o_packed_out !== wr_pkt) begin bad++; $display("FAIL bp_hold_pkt%0d got=%h exp=%h", c, o_packed_out, wr_pkt); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_nogrant%0d got=%b exp=0000", c, req_ready); end
      step();
    end
    o_ready_in = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release got=%b exp=1000", req_ready); end
    total++; if (o_packed_out !== wr_pkt) begin bad++; $display("FAIL bp_release_pkt got=%h exp=%h", o_packed_out, wr_pkt); end
    step();
    req_valid = '0;
    @(negedge clk);
    total++; if (o_packed_out !== rd_pkt) begin bad++; $display("FAIL bp_next_pkt got=%h exp=%h", o_packed_out, rd_pkt); end
    step();
    @(negedge clk);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b exp=0", o_valid_out); end
    step();
    i_valid_in = 1'b1;
    i_packed_in = {8'h80, 4'hF};
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL bp_ack_valid got=%b exp=0010", rsp_valid); end
    total++; if (rsp_data !== 8'h80) begin bad++; $display("FAIL bp_ack_data got=%h exp=80", rsp_data); end
    $display("write ack valid=%b data=%h", rsp_valid, rsp_data);
    step();
    i_valid_in = 1'b1;
    i_packed_in = {8'h77, 4'hF};
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 4'b1000) begin bad++; $display("FAIL bp_rd_valid got=%b exp=1000", rsp_valid); end
    total++; if (rsp_data !== 8'h77) begin bad++; $display("FAIL bp_rd_data got=%h exp=77", rsp_data); end
    step();
  endtask

  task automatic test_spurious();
    int grants;
    do_reset();
    i_valid_in = 1'b1;
    i_packed_in = {8'h55, 4'hF};
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL sp_err got=%b exp=1", err_out); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL sp_norsp got=%b exp=0000", rsp_valid); end
    step();
    step();
    @(negedge clk);
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL sp_sticky got=%b exp=1", err_out); end
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    req_valid = 4'b1111;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) grants++;
      step();
    end
    req_valid = '0;
    total++; if (grants !== 4) begin bad++; $display("FAIL sp_credits got=%0d exp=4", grants); end
    $display("spurious credits grants=%0d", grants);
    do_reset();
    @(negedge clk);
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL sp_reset_err got=%b exp=0", err_out); end
    step();
    i_valid_in = 1'b1;
    step();
    i_valid_in = 1'b0;
    @(negedge clk);
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL sp_late_err got=%b exp=1", err_out); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL sp_late_norsp got=%b exp=0000", rsp_valid); end
    step();
  endtask

  initial begin
    rst = 1'b0;
    req_write = '0;
    req_addr = '0;
    req_data = '0;
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_credit_return();
    test_backpressure();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
